// File: rtl/mac_pkg.sv
// Shared constants for the MAC framing path: FSM state codes, header bytes
// and the record size produced by the upstream record writer.
package mac_pkg;

   localparam logic [7:0] ST_IDLE = 8'h00;
   localparam logic [7:0] ST_HDR0 = 8'h01;
   localparam logic [7:0] ST_HDR1 = 8'h02;
   localparam logic [7:0] ST_SEQN = 8'h03;
   localparam logic [7:0] ST_PLD  = 8'h10;
   localparam logic [7:0] ST_CSUM = 8'h20;
   localparam logic [7:0] ST_LAST = 8'h80;

   localparam logic [7:0] HDR0_BYTE = 8'h55;
   localparam logic [7:0] HDR1_BYTE = 8'hAA;

   localparam int REC_BYTES = 12;

endpackage

// File: rtl/mac_frame_tx.sv
// Drains NUM_REC records from the record FIFO and emits one framed byte stream
// (header, sequence number, payload, XOR checksum) toward the MAC TX.
module mac_frame_tx
   import mac_pkg::*;
#(
   parameter int NUM_REC = 4,
   parameter int CNT_W   = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fs,
   output logic             fd,
   output logic [7:0]       so,
   input  logic [CNT_W-1:0] fifoe_rd_count,
   output logic             fifoe_rden,
   input  logic [7:0]       fifoe_rxd,
   output logic             mac_txen,
   output logic [7:0]       mac_txd
);

   localparam int               PLD_LEN    = NUM_REC * REC_BYTES;
   localparam logic [CNT_W-1:0] PLD_LEN_C  = CNT_W'(PLD_LEN);
   localparam logic [CNT_W-1:0] PLD_LAST_C = CNT_W'(PLD_LEN - 1);

   logic [7:0]       state;
   logic [7:0]       seq;
   logic [7:0]       csum;
   logic [CNT_W-1:0] cnt;

   assign fd = (state == ST_LAST);
   assign so = state;

   // The SEQN read primes the one-cycle FIFO latency, so PLD stops issuing
   // reads one byte early to keep the total at exactly PLD_LEN.
   assign fifoe_rden = (state == ST_SEQN) ||
                       ((state == ST_PLD) && (cnt < PLD_LAST_C));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mac_txen <= 1'b0;
         mac_txd  <= 8'h00;
         seq      <= 8'h00;
         csum     <= 8'h00;
         cnt      <= '0;
      end else begin
         mac_txen <= 1'b0;
         mac_txd  <= 8'h00;
         case (state)
            ST_IDLE: begin
               if (fs && (fifoe_rd_count >= PLD_LEN_C))
                  state <= ST_HDR0;
            end
            ST_HDR0: begin
               mac_txen <= 1'b1;
               mac_txd  <= HDR0_BYTE;
               state    <= ST_HDR1;
            end
            ST_HDR1: begin
               mac_txen <= 1'b1;
               mac_txd  <= HDR1_BYTE;
               state    <= ST_SEQN;
            end
            ST_SEQN: begin
               mac_txen <= 1'b1;
               mac_txd  <= seq;
               csum     <= seq;
               cnt      <= '0;
               state    <= ST_PLD;
            end
            ST_PLD: begin
               mac_txen <= 1'b1;
               mac_txd  <= fifoe_rxd;
               csum     <= csum ^ fifoe_rxd;
               if (cnt == PLD_LAST_C)
                  state <= ST_CSUM;
               else
                  cnt <= cnt + 1'b1;
            end
            ST_CSUM: begin
               mac_txen <= 1'b1;
               mac_txd  <= csum;
               seq      <= seq + 8'h01;
               state    <= ST_LAST;
            end
            ST_LAST: begin
               if (!fs)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
